result_drain_sched: RTL and testbench
=====================================

Name: result_drain_sched

Overview:
- Job-level output scheduler for the multi-core HPU.
- After a job starts, it waits until every participating core has reported done.
- It then drains one result word per participating core onto the AXI-Stream master output, in ascending core index order, honouring backpressure.
- It sits between the core array and the DMA stream port, and replaces ad-hoc "last" delay chains with an explicit per-core completion check.

Parameters:
- CORENUM, 16, number of cores; 1 to 64.
- DW, 32, result word width per core and stream data width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high; all state cleared on the clock edge where rst=1
- start  in  1  one-cycle pulse that begins a job
- core_en  in  CORENUM  participating-core mask, sampled only on an accepted start
- core_done  in  CORENUM  per-core done pulse or level; core i drives bit i
- core_data  in  CORENUM*DW  per-core result; core i occupies bits [i*DW +: DW]; held stable by the core from done until the next start
- dst_ready  in  1  stream sink ready
- dst_valid  out  1  stream word valid
- dst_data  out  DW  stream word
- dst_last  out  1  marks the final word of the job
- busy  out  1  1 while a job is in progress (state is not IDLE)
- err  out  1  sticky protocol-error flag

Behaviour:
- Reset values: dst_valid=0, dst_data=0, dst_last=0, busy=0, err=0, state=IDLE, en_mask=0, done_keep=0, ptr=0.
- FSM states: IDLE, COLLECT, DRAIN.
- IDLE:
  - start=1 with core_en!=0: latch en_mask=core_en, clear done_keep, go to COLLECT.
  - start=1 with core_en==0: no action; stay IDLE; no output produced; err unchanged.
  - core_done is ignored in IDLE.
- COLLECT:
  - Each cycle: done_keep <= done_keep | (core_done & en_mask).
  - Done bits from non-enabled cores are ignored.
  - Completion condition: (done_keep | (core_done & en_mask)) == en_mask in cycle t.
  - On completion in cycle t, at t+1: state=DRAIN, ptr = lowest set index of en_mask, dst_valid=1, dst_data=core_data[ptr], dst_last = (ptr is the highest set index).
  - All-done-in-one-cycle and staggered done arrival behave identically.
- DRAIN:
  - dst_valid, dst_data and dst_last are registered and held stable while dst_valid & !dst_ready.
  - Handshake occurs when dst_valid & dst_ready.
  - On a handshake with dst_last=0: ptr advances to the next set bit of en_mask above ptr; dst_data and dst_last are reloaded the next cycle; dst_valid stays 1.
  - With dst_ready held high, throughput is one word per cycle with no bubbles.
  - On a handshake with dst_last=1: next cycle dst_valid=0, dst_last=0, state=IDLE.
  - dst_data keeps its last value after the final handshake.
- Word count and order:
  - Exactly popcount(en_mask) words per job.
  - Ascending core index; disabled cores are skipped with no gap cycle.
  - A single-core job emits one word with dst_last=1.
- busy: 1 from the cycle after an accepted start through the cycle of the final handshake; 0 the cycle after.
  - An accepted start may be issued in the first cycle busy=0.
- Protocol errors (set err=1, sticky until rst):
  - start while busy=1: the start is ignored and the job continues unaffected.
  - A core_done bit of an enabled core arriving while state=DRAIN: ignored.
- Reset mid-operation (any state): outputs return to reset values at the next edge.
  - Partial jobs are discarded; no dst_last is emitted.
- Width rules:
  - ptr is clog2(CORENUM) bits, minimum 1.
  - Next/lowest/highest set-bit searches are combinational priority encoders over en_mask.
  - No arithmetic overflow is possible.

Test Plan:
- CORENUM=4, DW=32. start with core_en=4'b1111, core_data words A0..A3, core_done=4'b1111 in one cycle, dst_ready=1 -> dst_valid rises the next cycle; 4 consecutive words A0,A1,A2,A3; dst_last only on A3; busy falls after the A3 handshake.
- core_en=4'b1010; core_done bit1 at t, bit3 at t+5, stray bit0 at t+2 -> no output before t+6; words A1 then A3 (dst_last) from t+6; stray done ignored; err=0.
- Backpressure: core_en=1111, dst_ready toggling 1,0,0,1,0,1,1 -> each word held stable while ready=0; no word lost or duplicated; total 4 handshakes, last on A3.
- start pulsed again during COLLECT and again during DRAIN -> err=1 and stays 1; the original job completes normally with 4 words; busy never drops early.
- rst asserted during DRAIN after 2 handshakes -> next cycle dst_valid=0, busy=0, err=0; a fresh start with core_en=0001 then emits a single word A0 with dst_last=1.
- start with core_en=0 -> busy stays 0, dst_valid stays 0, err=0.

Source files
------------

// File: rtl/result_drain_sched.sv
`default_nettype none
// ============================================================================
// Module   : result_drain_sched
// Brief    : Waits for every enabled core to report done, then streams one
//            result word per enabled core in ascending core order.
// Revision : 1.0 - initial release
// ============================================================================
module result_drain_sched #(
    parameter int CORENUM = 16,
    parameter int DW      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CORENUM-1:0]    core_en,
    input  logic [CORENUM-1:0]    core_done,
    input  logic [CORENUM*DW-1:0] core_data,
    input  logic                  dst_ready,
    output logic                  dst_valid,
    output logic [DW-1:0]         dst_data,
    output logic                  dst_last,
    output logic                  busy,
    output logic                  err
);

    localparam int PW = (CORENUM > 1) ? $clog2(CORENUM) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    state_t               state_q;
    logic [CORENUM-1:0]   en_mask_q;
    logic [CORENUM-1:0]   done_keep_q;
    logic [PW-1:0]        ptr_q;
    logic                 valid_q;
    logic [DW-1:0]        data_q;
    logic                 last_q;
    logic                 err_q;

    logic [DW-1:0]        words [CORENUM];
    logic [CORENUM-1:0]   done_merge_d;
    logic [PW-1:0]        low_idx_d;
    logic [PW-1:0]        high_idx_d;
    logic [PW-1:0]        next_idx_d;

    generate
        for (genvar gi = 0; gi < CORENUM; gi++) begin : g_words
            assign words[gi] = core_data[gi*DW +: DW];
        end
    endgenerate

    assign done_merge_d = done_keep_q | (core_done & en_mask_q);

    // Priority encoders over the latched mask: lowest, highest and next-above-ptr.
    always_comb begin
        low_idx_d  = '0;
        high_idx_d = '0;
        next_idx_d = '0;
        for (int i = CORENUM - 1; i >= 0; i--) begin
            if (en_mask_q[i]) begin
                low_idx_d = PW'(i);
                if (i > int'(ptr_q)) begin
                    next_idx_d = PW'(i);
                end
            end
        end
        for (int i = 0; i < CORENUM; i++) begin
            if (en_mask_q[i]) begin
                high_idx_d = PW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            en_mask_q   <= '0;
            done_keep_q <= '0;
            ptr_q       <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && (core_en != '0)) begin
                        en_mask_q   <= core_en;
                        done_keep_q <= '0;
                        state_q     <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    done_keep_q <= done_merge_d;
                    if (start) begin
                        err_q <= 1'b1;
                    end
                    if (done_merge_d == en_mask_q) begin
                        state_q <= S_DRAIN;
                        ptr_q   <= low_idx_d;
                        valid_q <= 1'b1;
                        data_q  <= words[low_idx_d];
                        last_q  <= (low_idx_d == high_idx_d);
                    end
                end
                S_DRAIN: begin
                    // A second done from an enabled core means it restarted mid-job.
                    if (start || ((core_done & en_mask_q) != '0)) begin
                        err_q <= 1'b1;
                    end
                    if (valid_q && dst_ready) begin
                        if (last_q) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            ptr_q  <= next_idx_d;
                            data_q <= words[next_idx_d];
                            last_q <= (next_idx_d == high_idx_d);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign dst_valid = valid_q;
    assign dst_data  = data_q;
    assign dst_last  = last_q;
    assign busy      = (state_q != S_IDLE);
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_result_drain_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_drain_sched
// Brief    : Directed self-checking bench for result_drain_sched (4 cores).
// Revision : 1.0 - initial release
// ============================================================================
module tb_result_drain_sched;

    localparam int CORENUM = 4;
    localparam int DW      = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [CORENUM-1:0]    core_en;
    logic [CORENUM-1:0]    core_done;
    logic [CORENUM*DW-1:0] core_data;
    logic                  dst_ready;
    logic                  dst_valid;
    logic [DW-1:0]         dst_data;
    logic                  dst_last;
    logic                  busy;
    logic                  err;

    int n_checks = 0;
    int n_fail   = 0;

    result_drain_sched #(.CORENUM(CORENUM), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .core_en   (core_en),
        .core_done (core_done),
        .core_data (core_data),
        .dst_ready (dst_ready),
        .dst_valid (dst_valid),
        .dst_data  (dst_data),
        .dst_last  (dst_last),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_data(input logic [DW-1:0] base);
        for (int i = 0; i < CORENUM; i++) core_data[i*DW +: DW] = base + DW'(i);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; core_en = '0; core_done = '0;
        core_data = '0; dst_ready = 1'b1;
        tick(); tick();
        n_checks++;
        if ({dst_valid, dst_last, busy, err} !== 4'b0000 || dst_data !== '0) begin
            n_fail++;
            $display("FAIL reset: valid/last/busy/err=%b data=%h, want 0000 / 0",
                     {dst_valid, dst_last, busy, err}, dst_data);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_all_at_once();
        set_data(32'hA000_0000);
        start = 1'b1; core_en = 4'b1111;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || dst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL collect_entry: busy=%b valid=%b, want 1 0", busy, dst_valid);
        end
        core_done = 4'b1111;
        tick();
        core_done = '0;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (dst_valid !== 1'b1 || dst_data !== 32'hA000_0000 + k ||
                dst_last !== (k == 3) || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL burst_word%0d: valid=%b data=%h last=%b busy=%b, want 1 %h %b 1",
                         k, dst_valid, dst_data, dst_last, busy, 32'hA000_0000 + k, (k == 3));
            end
            tick();
        end
        n_checks++;
        if (dst_valid !== 1'b0 || dst_last !== 1'b0 || busy !== 1'b0 ||
            dst_data !== 32'hA000_0003 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_end: valid=%b last=%b busy=%b data=%h err=%b, want 0 0 0 a0000003 0",
                     dst_valid, dst_last, busy, dst_data, err);
        end
    endtask

    // Starts in the very first idle cycle after the previous job.
    task automatic test_back_to_back();
        set_data(32'hB000_0000);
        start = 1'b1; core_en = 4'b0100;
        tick();
        start = 1'b0; core_done = 4'b0100;
        tick();
        core_done = '0;
        n_checks++;
        if (dst_valid !== 1'b1 || dst_data !== 32'hB000_0002 || dst_last !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_single: valid=%b data=%h last=%b, want 1 b0000002 1",
                     dst_valid, dst_data, dst_last);
        end
        tick();
        n_checks++;
        if (dst_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: valid=%b busy=%b, want 0 0", dst_valid, busy);
        end
    endtask

    task automatic test_staggered();
        set_data(32'hC000_0000);
        start = 1'b1; core_en = 4'b1010;
        tick();
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (dst_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stagger_early%0d: valid=%b, want 0", k, dst_valid);
            end
            core_done = (k == 0) ? 4'b0010 : (k == 2) ? 4'b0001 : (k == 5) ? 4'b1000 : 4'b0000;
            tick();
        end
        core_done = '0;
        n_checks++;
        if (dst_valid !== 1'b1 || dst_data !== 32'hC000_0001 || dst_last !== 1'b0) begin
            n_fail++;
            $display("FAIL stagger_w1: valid=%b data=%h last=%b, want 1 c0000001 0",
                     dst_valid, dst_data, dst_last);
        end
        tick();
        n_checks++;
        if (dst_valid !== 1'b1 || dst_data !== 32'hC000_0003 || dst_last !== 1'b1) begin
            n_fail++;
            $display("FAIL stagger_w3: valid=%b data=%h last=%b, want 1 c0000003 1",
                     dst_valid, dst_data, dst_last);
        end
        tick();
        n_checks++;
        if (dst_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL stagger_end: valid=%b busy=%b err=%b, want 0 0 0", dst_valid, busy, err);
        end
    endtask

    task automatic test_backpressure();
        logic [6:0] pat;
        logic [DW-1:0] held;
        logic       was_stalled;
        int         hs;
        pat = 7'b1101001;   // bit k applies at step k: 1,0,0,1,0,1,1
        hs = 0; was_stalled = 1'b0; held = '0;
        set_data(32'hD000_0000);
        start = 1'b1; core_en = 4'b1111;
        tick();
        start = 1'b0; core_done = 4'b1111;
        tick();
        core_done = '0;
        for (int k = 0; k < 7; k++) begin
            dst_ready = pat[k];
            if (was_stalled) begin
                n_checks++;
                if (dst_data !== held) begin
                    n_fail++;
                    $display("FAIL bp_hold%0d: data=%h, want %h", k, dst_data, held);
                end
            end
            n_checks++;
            if (dst_valid !== 1'b1 || dst_data !== 32'hD000_0000 + hs || dst_last !== (hs == 3)) begin
                n_fail++;
                $display("FAIL bp_step%0d: valid=%b data=%h last=%b, want 1 %h %b",
                         k, dst_valid, dst_data, dst_last, 32'hD000_0000 + hs, (hs == 3));
            end
            was_stalled = !pat[k];
            held = dst_data;
            if (pat[k]) hs++;
            tick();
        end
        dst_ready = 1'b1;
        n_checks++;
        if (hs != 4 || dst_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_end: handshakes=%0d valid=%b busy=%b, want 4 0 0", hs, dst_valid, busy);
        end
    endtask

    task automatic test_start_while_busy();
        set_data(32'hE000_0000);
        start = 1'b1; core_en = 4'b1111;
        tick();
        start = 1'b1;               // retrigger during COLLECT
        tick();
        start = 1'b0;
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL err_collect: err=%b busy=%b, want 1 1", err, busy);
        end
        core_done = 4'b1111;
        tick();
        core_done = '0; dst_ready = 1'b0; start = 1'b1;   // retrigger during DRAIN
        tick();
        start = 1'b0; dst_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (dst_valid !== 1'b1 || dst_data !== 32'hE000_0000 + k || dst_last !== (k == 3) ||
                busy !== 1'b1 || err !== 1'b1) begin
                n_fail++;
                $display("FAIL err_word%0d: valid=%b data=%h last=%b busy=%b err=%b, want 1 %h %b 1 1",
                         k, dst_valid, dst_data, dst_last, busy, err, 32'hE000_0000 + k, (k == 3));
            end
            tick();
        end
        n_checks++;
        if (dst_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: valid=%b busy=%b err=%b, want 0 0 1", dst_valid, busy, err);
        end
    endtask

    task automatic test_reset_mid_drain();
        set_data(32'hF000_0000);
        start = 1'b1; core_en = 4'b1111;
        tick();
        start = 1'b0; core_done = 4'b1111;
        tick();
        core_done = '0;
        tick(); tick();             // two handshakes done, A2 now presented
        n_checks++;
        if (dst_data !== 32'hF000_0002) begin
            n_fail++;
            $display("FAIL rst_pre: data=%h, want f0000002", dst_data);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (dst_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || dst_last !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: valid=%b busy=%b err=%b last=%b, want 0 0 0 0",
                     dst_valid, busy, err, dst_last);
        end
        start = 1'b1; core_en = 4'b0001;
        tick();
        start = 1'b0; core_done = 4'b0001;
        tick();
        core_done = '0;
        n_checks++;
        if (dst_valid !== 1'b1 || dst_data !== 32'hF000_0000 || dst_last !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_fresh: valid=%b data=%h last=%b, want 1 f0000000 1",
                     dst_valid, dst_data, dst_last);
        end
        tick();
    endtask

    task automatic test_zero_mask();
        start = 1'b1; core_en = 4'b0000;
        tick();
        start = 1'b0; core_done = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (busy !== 1'b0 || dst_valid !== 1'b0 || err !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_mask%0d: busy=%b valid=%b err=%b, want 0 0 0", k, busy, dst_valid, err);
            end
            tick();
        end
        core_done = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_all_at_once();
        test_back_to_back();
        test_staggered();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_drain();
        test_zero_mask();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
